// File: rtl/tl_ul_arbiter_2to1.sv
// Two-master to one-slave TileLink-UL arbiter.
// Master 0 is the instruction port and master 1 is the data port. One A beat
// is granted at a time with round-robin priority, registered, and sent to the
// slave. The single outstanding response is then routed back to its owner.
// Optional response watchdog: define TLUL_ARB_TIMEOUT_EN.
module tl_ul_arbiter_2to1 #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            m_a_valid_i,
  input  logic [5:0]            m_a_opcode_i,
  input  logic [2*ADDR_W-1:0]   m_a_address_i,
  input  logic [2*DATA_W-1:0]   m_a_data_i,
  input  logic [3:0]            m_a_size_i,
  input  logic [3:0]            m_a_mask_i,
  output logic [1:0]            m_a_ready_o,
  output logic [1:0]            m_d_valid_o,
  output logic [2:0]            m_d_opcode_o,
  output logic [1:0]            m_d_size_o,
  output logic [DATA_W-1:0]     m_d_data_o,
  input  logic [1:0]            m_d_ready_i,
  output logic                  s_a_valid_o,
  output logic [2:0]            s_a_opcode_o,
  output logic [ADDR_W-1:0]     s_a_address_o,
  output logic [DATA_W-1:0]     s_a_data_o,
  output logic [1:0]            s_a_size_o,
  output logic [1:0]            s_a_mask_o,
  input  logic                  s_a_ready_i,
  input  logic                  s_d_valid_i,
  input  logic [2:0]            s_d_opcode_i,
  input  logic [1:0]            s_d_size_i,
  input  logic [DATA_W-1:0]     s_d_data_i,
  output logic                  s_d_ready_o,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [2:0]          s_a_opcode_q, s_a_opcode_d;
  logic [ADDR_W-1:0]   s_a_address_q, s_a_address_d;
  logic [DATA_W-1:0]   s_a_data_q, s_a_data_d;
  logic [1:0]          s_a_size_q, s_a_size_d;
  logic [1:0]          s_a_mask_q, s_a_mask_d;

  logic                any_req;
  logic                winner;
  logic [2:0]          win_opcode;
  logic [ADDR_W-1:0]   win_address;
  logic [DATA_W-1:0]   win_data;
  logic [1:0]          win_size;
  logic [1:0]          win_mask;

`ifdef TLUL_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
`endif

  // Round-robin pick: a lone requester wins, a tie goes to the master not granted last.
  always_comb begin
    any_req     = |m_a_valid_i;
    winner      = (&m_a_valid_i) ? ~last_grant_q : m_a_valid_i[1];
    win_opcode  = winner ? m_a_opcode_i[5:3] : m_a_opcode_i[2:0];
    win_address = winner ? m_a_address_i[2*ADDR_W-1:ADDR_W] : m_a_address_i[ADDR_W-1:0];
    win_data    = winner ? m_a_data_i[2*DATA_W-1:DATA_W] : m_a_data_i[DATA_W-1:0];
    win_size    = winner ? m_a_size_i[3:2] : m_a_size_i[1:0];
    win_mask    = winner ? m_a_mask_i[3:2] : m_a_mask_i[1:0];
  end

  // Next-state and output decode for the IDLE/REQ/RESP transaction sequencer.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    s_a_opcode_d  = s_a_opcode_q;
    s_a_address_d = s_a_address_q;
    s_a_data_d    = s_a_data_q;
    s_a_size_d    = s_a_size_q;
    s_a_mask_d    = s_a_mask_q;
    m_a_ready_o   = 2'b00;
    m_d_valid_o   = 2'b00;
    m_d_opcode_o  = 3'd0;
    m_d_size_o    = 2'd0;
    m_d_data_o    = '0;
    s_a_valid_o   = 1'b0;
    s_d_ready_o   = 1'b0;
`ifdef TLUL_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        // Ready is gated by reset so an asserted reset never shows a grant.
        if (any_req && reset) begin
          m_a_ready_o[winner] = 1'b1;
          s_a_opcode_d        = win_opcode;
          s_a_address_d       = win_address;
          s_a_data_d          = win_data;
          s_a_size_d          = win_size;
          s_a_mask_d          = win_mask;
          owner_d             = winner;
          last_grant_d        = winner;
          state_d             = REQ;
        end
      end
      REQ: begin
        s_a_valid_o = 1'b1;
`ifdef TLUL_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
        if (s_a_ready_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
`ifdef TLUL_ARB_TIMEOUT_EN
        if (cnt_q == CNT_LIMIT) begin
          // Slave gave up on: answer locally and ignore the slave from now on.
          m_d_valid_o[owner_q] = 1'b1;
          m_d_opcode_o         = (s_a_opcode_q == 3'd4) ? 3'd1 : 3'd0;
          m_d_size_o           = s_a_size_q;
          m_d_data_o           = ERR_DATA;
          timeout_d            = 1'b1;
          if (m_d_ready_i[owner_q]) begin
            state_d = IDLE;
          end
        end else begin
          m_d_valid_o[owner_q] = s_d_valid_i;
          m_d_opcode_o         = s_d_opcode_i;
          m_d_size_o           = s_d_size_i;
          m_d_data_o           = s_d_data_i;
          s_d_ready_o          = m_d_ready_i[owner_q];
          if (!s_d_valid_i) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (s_d_valid_i && m_d_ready_i[owner_q]) begin
            state_d = IDLE;
          end
        end
`else
        m_d_valid_o[owner_q] = s_d_valid_i;
        m_d_opcode_o         = s_d_opcode_i;
        m_d_size_o           = s_d_size_i;
        m_d_data_o           = s_d_data_i;
        s_d_ready_o          = m_d_ready_i[owner_q];
        if (s_d_valid_i && m_d_ready_i[owner_q]) begin
          state_d = IDLE;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state, ownership, round-robin history and the registered A beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      s_a_opcode_q  <= 3'd0;
      s_a_address_q <= '0;
      s_a_data_q    <= '0;
      s_a_size_q    <= 2'd0;
      s_a_mask_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      s_a_opcode_q  <= s_a_opcode_d;
      s_a_address_q <= s_a_address_d;
      s_a_data_q    <= s_a_data_d;
      s_a_size_q    <= s_a_size_d;
      s_a_mask_q    <= s_a_mask_d;
    end
  end

`ifdef TLUL_ARB_TIMEOUT_EN
  // Watchdog counter and its sticky flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign s_a_opcode_o  = s_a_opcode_q;
  assign s_a_address_o = s_a_address_q;
  assign s_a_data_o    = s_a_data_q;
  assign s_a_size_o    = s_a_size_q;
  assign s_a_mask_o    = s_a_mask_q;

endmodule

// File: tb/tb_tl_ul_arbiter_2to1.sv
// Testbench for tl_ul_arbiter_2to1: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_tl_ul_arbiter_2to1;
  localparam int AW = 12;
  localparam int DW = 32;
`ifdef TLUL_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      m_a_valid_i;
  logic [5:0]      m_a_opcode_i;
  logic [2*AW-1:0] m_a_address_i;
  logic [2*DW-1:0] m_a_data_i;
  logic [3:0]      m_a_size_i;
  logic [3:0]      m_a_mask_i;
  logic [1:0]      m_a_ready_o;
  logic [1:0]      m_d_valid_o;
  logic [2:0]      m_d_opcode_o;
  logic [1:0]      m_d_size_o;
  logic [DW-1:0]   m_d_data_o;
  logic [1:0]      m_d_ready_i;
  logic            s_a_valid_o;
  logic [2:0]      s_a_opcode_o;
  logic [AW-1:0]   s_a_address_o;
  logic [DW-1:0]   s_a_data_o;
  logic [1:0]      s_a_size_o;
  logic [1:0]      s_a_mask_o;
  logic            s_a_ready_i;
  logic            s_d_valid_i;
  logic [2:0]      s_d_opcode_i;
  logic [1:0]      s_d_size_i;
  logic [DW-1:0]   s_d_data_i;
  logic            s_d_ready_o;
  logic            timeout_o;

  tl_ul_arbiter_2to1 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m_a_valid_i(m_a_valid_i), .m_a_opcode_i(m_a_opcode_i), .m_a_address_i(m_a_address_i),
    .m_a_data_i(m_a_data_i), .m_a_size_i(m_a_size_i), .m_a_mask_i(m_a_mask_i),
    .m_a_ready_o(m_a_ready_o), .m_d_valid_o(m_d_valid_o), .m_d_opcode_o(m_d_opcode_o),
    .m_d_size_o(m_d_size_o), .m_d_data_o(m_d_data_o), .m_d_ready_i(m_d_ready_i),
    .s_a_valid_o(s_a_valid_o), .s_a_opcode_o(s_a_opcode_o), .s_a_address_o(s_a_address_o),
    .s_a_data_o(s_a_data_o), .s_a_size_o(s_a_size_o), .s_a_mask_o(s_a_mask_o),
    .s_a_ready_i(s_a_ready_i), .s_d_valid_i(s_d_valid_i), .s_d_opcode_i(s_d_opcode_i),
    .s_d_size_i(s_d_size_i), .s_d_data_i(s_d_data_i), .s_d_ready_o(s_d_ready_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    size;
    logic [1:0]    mask;
  } req_t;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: requests waiting at each master, the one transaction in
  // flight (granted, then accepted by the slave), and the round-robin history.
  bit   m_pend [2];
  req_t m_req  [2];
  bit   out_vld, out_acc;
  int   out_own;
  req_t out_req;
  int   last_g;
  // Slave environment.
  bit   env_pend;
  req_t env_req;
  // Observations of the DUT for ordering checks.
  int            dut_grants[$];
  logic [2:0]    slave_ops[$];
  logic [DW-1:0] m_resp_data[$];
  // Stimulus knobs (percent).
  int p_req, p_drop, p_sar, p_sdv, p_mdr, p_spur;

  function automatic bit rnd(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   k;
    k      = $urandom_range(0, 2);
    r.op   = (k == 0) ? 3'd0 : ((k == 1) ? 3'd1 : 3'd4);
    r.addr = AW'($urandom);
    r.data = $urandom;
    r.size = 2'($urandom_range(0, 2));
    r.mask = 2'($urandom);
    return r;
  endfunction

  // The slave answers a Get with address+3 as data, a Put with AccessAck.
  function automatic logic [2:0] rsp_op(input req_t r);
    return (r.op == 3'd4) ? 3'd1 : 3'd0;
  endfunction

  function automatic logic [DW-1:0] rsp_data(input req_t r);
    return (r.op == 3'd4) ? (DW'(r.addr) + 32'd3) : '0;
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < 2; k++) begin
      if (m_pend[k] && rnd(p_drop)) m_pend[k] = 1'b0;
      if (!m_pend[k] && rnd(p_req)) begin
        m_pend[k] = 1'b1;
        m_req[k]  = rand_req();
      end
    end
    m_a_valid_i   = {m_pend[1], m_pend[0]};
    m_a_opcode_i  = {m_req[1].op, m_req[0].op};
    m_a_address_i = {m_req[1].addr, m_req[0].addr};
    m_a_data_i    = {m_req[1].data, m_req[0].data};
    m_a_size_i    = {m_req[1].size, m_req[0].size};
    m_a_mask_i    = {m_req[1].mask, m_req[0].mask};
    s_a_ready_i   = rnd(p_sar);
    if (env_pend) begin
      s_d_valid_i  = rnd(p_sdv);
      s_d_opcode_i = rsp_op(env_req);
      s_d_size_i   = env_req.size;
      s_d_data_i   = rsp_data(env_req);
    end else begin
      s_d_valid_i  = rnd(p_spur);
      s_d_opcode_i = 3'd1;
      s_d_size_i   = 2'($urandom);
      s_d_data_i   = $urandom;
    end
    m_d_ready_i = {rnd(p_mdr), rnd(p_mdr)};
  endtask

  // Called away from the clock edge: compare outputs, then advance model and
  // slave environment by the handshakes the coming edge will complete.
  task automatic check_cycle();
    logic [1:0] er;
    logic [1:0] emdv;
    int         w;
    bit         resp;
    bit         a_hs, d_hs;
    er = 2'b00;
    w  = 0;
    if (!out_vld && (m_pend[0] || m_pend[1])) begin
      w = (m_pend[0] && m_pend[1]) ? (1 - last_g) : (m_pend[1] ? 1 : 0);
      er[w] = 1'b1;
    end
    resp = out_vld && out_acc;
    emdv = (resp && s_d_valid_i) ? (2'b01 << out_own) : 2'b00;
    check("m_a_ready", 64'(m_a_ready_o), 64'(er));
    check("s_a_valid", 64'(s_a_valid_o), 64'(out_vld && !out_acc));
    if (out_vld && !out_acc)
      check("s_a_beat", 64'({s_a_opcode_o, s_a_address_o, s_a_data_o, s_a_size_o, s_a_mask_o}),
            64'(out_req));
    check("m_d_valid", 64'(m_d_valid_o), 64'(emdv));
    check("s_d_ready", 64'(s_d_ready_o), 64'(resp ? m_d_ready_i[out_own] : 1'b0));
    if (resp && s_d_valid_i)
      check("m_d_beat", 64'({m_d_opcode_o, m_d_size_o, m_d_data_o}),
            64'({rsp_op(out_req), out_req.size, rsp_data(out_req)}));
    // Observation logs.
    if (m_a_ready_o != 2'b00) dut_grants.push_back(m_a_ready_o[1] ? 1 : 0);
    a_hs = s_a_valid_o && s_a_ready_i;
    d_hs = s_d_valid_i && s_d_ready_o;
    if (a_hs) slave_ops.push_back(s_a_opcode_o);
    if ((m_d_valid_o & m_d_ready_i) != 2'b00) m_resp_data.push_back(m_d_data_o);
    // Model update.
    if (er != 2'b00) begin
      out_vld   = 1'b1;
      out_acc   = 1'b0;
      out_own   = w;
      out_req   = m_req[w];
      last_g    = w;
      m_pend[w] = 1'b0;
    end else if (out_vld && !out_acc && s_a_ready_i) begin
      out_acc = 1'b1;
    end else if (resp && s_d_valid_i && m_d_ready_i[out_own]) begin
      out_vld = 1'b0;
    end
    // Slave environment update from what it actually saw.
    if (a_hs) begin
      env_pend     = 1'b1;
      env_req.op   = s_a_opcode_o;
      env_req.addr = s_a_address_o;
      env_req.data = s_a_data_o;
      env_req.size = s_a_size_o;
      env_req.mask = s_a_mask_o;
    end else if (d_hs) begin
      env_pend = 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive_inputs();
      @(negedge clk);
      check_cycle();
    end
  endtask

  task automatic clear_model();
    m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    out_vld = 1'b0; out_acc = 1'b0; out_own = 0;
    last_g = 1; env_pend = 1'b0;
    dut_grants.delete(); slave_ops.delete(); m_resp_data.delete();
  endtask

  task automatic set_knobs(input int rq, input int dr, input int sar, input int sdv,
                           input int mdr, input int spur);
    p_req = rq; p_drop = dr; p_sar = sar; p_mdr = mdr; p_spur = spur;
`ifdef TLUL_ARB_TIMEOUT_EN
    p_sdv = 100;
`else
    p_sdv = sdv;
`endif
  endtask

  // Asynchronous reset with live traffic on every input: outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #1;
    m_a_valid_i = 2'b11; s_d_valid_i = 1'b1; m_d_ready_i = 2'b11;
    #1;
    reset = 1'b0;
    #1;
    check("rst_m_a_ready", 64'(m_a_ready_o), 64'(2'b00));
    check("rst_s_a_valid", 64'(s_a_valid_o), 64'(1'b0));
    check("rst_m_d_valid", 64'(m_d_valid_o), 64'(2'b00));
    check("rst_s_d_ready", 64'(s_d_ready_o), 64'(1'b0));
    check("rst_s_a_beat", 64'({s_a_opcode_o, s_a_address_o, s_a_data_o, s_a_size_o, s_a_mask_o}),
          64'(0));
    check("rst_timeout", 64'(timeout_o), 64'(1'b0));
    m_a_valid_i = 2'b00; s_d_valid_i = 1'b0; m_d_ready_i = 2'b00; s_a_ready_i = 1'b0;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required to finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int n;
    clear_model();
    set_knobs(0, 0, 100, 100, 100, 0);
    // Both masters requesting while reset is held.
    reset = 1'b0;
    m_req[0] = '{op: 3'd4, addr: 12'h000, data: 32'h0, size: 2'd2, mask: 2'b11};
    m_req[1] = '{op: 3'd0, addr: 12'h100, data: 32'hCAFE_0001, size: 2'd2, mask: 2'b11};
    m_pend[0] = 1'b1; m_pend[1] = 1'b1;
    m_a_valid_i   = 2'b11;
    m_a_opcode_i  = {m_req[1].op, m_req[0].op};
    m_a_address_i = {m_req[1].addr, m_req[0].addr};
    m_a_data_i    = {m_req[1].data, m_req[0].data};
    m_a_size_i    = {m_req[1].size, m_req[0].size};
    m_a_mask_i    = {m_req[1].mask, m_req[0].mask};
    s_a_ready_i = 1'b1; s_d_valid_i = 1'b0; s_d_opcode_i = 3'd0; s_d_size_i = 2'd0;
    s_d_data_i = '0; m_d_ready_i = 2'b11;
    #2;
    check("init_m_a_ready", 64'(m_a_ready_o), 64'(2'b00));
    check("init_s_a_valid", 64'(s_a_valid_o), 64'(1'b0));
    check("init_m_d_valid", 64'(m_d_valid_o), 64'(2'b00));
    check("init_s_d_ready", 64'(s_d_ready_o), 64'(1'b0));
    check("init_s_a_beat", 64'({s_a_opcode_o, s_a_address_o, s_a_data_o, s_a_size_o, s_a_mask_o}),
          64'(0));
    check("init_timeout", 64'(timeout_o), 64'(1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_cycle();
    run(12);
    check("tie_n_grants", 64'(dut_grants.size()), 64'(2));
    check("tie_first_grant", 64'(dut_grants[0]), 64'(0));
    check("tie_second_grant", 64'(dut_grants[1]), 64'(1));
    check("tie_slave_op0", 64'(slave_ops[0]), 64'(3'd4));
    check("tie_slave_op1", 64'(slave_ops[1]), 64'(3'd0));

    // Single Get from master 0 at 12'h010.
    dut_grants.delete(); m_resp_data.delete();
    m_pend[0] = 1'b1;
    m_req[0]  = '{op: 3'd4, addr: 12'h010, data: 32'h0, size: 2'd2, mask: 2'b11};
    run(6);
    check("get010_n_resp", 64'(m_resp_data.size()), 64'(1));
    check("get010_data", 64'(m_resp_data[0]), 64'(32'h0000_0013));

    // Spurious slave response while idle.
    set_knobs(0, 0, 100, 100, 100, 100);
    run(5);

    // Continuous contention: grants alternate 0,1,0,1,0,1.
    do_reset();
    set_knobs(100, 0, 100, 100, 100, 0);
    n = 0;
    while (dut_grants.size() < 6 && n < 60) begin
      run(1);
      n++;
    end
    check("alt_n_grants", 64'(dut_grants.size() >= 6), 64'(1));
    for (int i = 0; i < 6; i++) check("alt_grant", 64'(dut_grants[i]), 64'(i % 2));

    // Slave stalls A for 4 cycles while master 1 raises valid.
    do_reset();
    set_knobs(0, 0, 0, 100, 100, 0);
    m_pend[0] = 1'b1;
    m_req[0]  = rand_req();
    run(1);
    m_pend[1] = 1'b1;
    m_req[1]  = rand_req();
    run(4);
    set_knobs(0, 0, 100, 100, 100, 0);
    run(10);
    check("stall_n_grants", 64'(dut_grants.size()), 64'(2));
    check("stall_order", 64'({dut_grants[0][0], dut_grants[1][0]}), 64'(2'b01));

    // Randomized traffic, with a reset in the middle of a response.
    set_knobs(40, 5, 60, 60, 60, 20);
    run(1500);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      run(1);
      got = out_vld && out_acc;
    end
    check("wait_resp_phase", 64'(got), 64'(1));
    do_reset();
    set_knobs(0, 0, 100, 100, 100, 0);
    m_pend[0] = 1'b1;
    m_req[0]  = rand_req();
    run(6);
    check("post_rst_n_resp", 64'(m_resp_data.size()), 64'(1));
    set_knobs(40, 5, 60, 60, 60, 20);
    run(1500);

`ifdef TLUL_ARB_TIMEOUT_EN
    // Slave never answers a Get: local error response after 8 RESP cycles.
    do_reset();
    set_knobs(0, 0, 100, 0, 0, 0);
    p_sdv = 0;
    m_pend[0] = 1'b1;
    m_req[0]  = '{op: 3'd4, addr: 12'h020, data: 32'h0, size: 2'd2, mask: 2'b11};
    run(2);
    n = 0;
    @(negedge clk);
    while (m_d_valid_o == 2'b00 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("to_wait_cycles", 64'(n), 64'(8));
    check("to_m_d_valid", 64'(m_d_valid_o), 64'(2'b01));
    check("to_m_d_data", 64'(m_d_data_o), 64'(32'hDEAD_BEEF));
    check("to_m_d_opcode", 64'(m_d_opcode_o), 64'(3'd1));
    check("to_m_d_size", 64'(m_d_size_o), 64'(2'd2));
    check("to_flag", 64'(timeout_o), 64'(1'b1));
    m_d_ready_i = 2'b01;
    @(negedge clk);
    check("to_done_m_d_valid", 64'(m_d_valid_o), 64'(2'b00));
    m_d_ready_i = 2'b00;
    s_d_valid_i = 1'b1;
    #1;
    check("to_late_s_d_ready", 64'(s_d_ready_o), 64'(1'b0));
    repeat (3) @(negedge clk);
    check("to_flag_sticky", 64'(timeout_o), 64'(1'b1));
    s_d_valid_i = 1'b0;
`else
    check("no_timeout_flag", 64'(timeout_o), 64'(1'b0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/tl_ul_arbiter_2to1.md
Name: tl_ul_arbiter_2to1

Overview:
- Two-master to one-slave TileLink-UL arbiter.
- Sits directly downstream of the channel_a request formatters and directly upstream of a single unified memory adapter, so instruction fetch and data access share one memory port.
- Grants one request at a time using round-robin priority and registers the granted A beat.
- Tracks the single outstanding transaction and routes the slave's D response back to the owning master.
- Master 0 = instruction port, master 1 = data port.

Parameters:
ADDR_W, 12, A-channel address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 255, response watchdog limit (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
m_a_valid_i  input  2  per-master A valid, bit k = master k
m_a_opcode_i  input  2x3  per-master A opcode (0 PutFull, 1 PutPartial, 4 Get)
m_a_address_i  input  2xADDR_W  per-master address
m_a_data_i  input  2xDATA_W  per-master write data
m_a_size_i  input  2x2  per-master size
m_a_mask_i  input  2x2  per-master mask
m_a_ready_o  output  2  per-master A accept
m_d_valid_o  output  2  per-master D valid
m_d_opcode_o  output  3  D opcode, shared bus
m_d_size_o  output  2  D size, shared bus
m_d_data_o  output  DATA_W  D data, shared bus
m_d_ready_i  input  2  per-master D ready
s_a_valid_o  output  1  slave A valid
s_a_opcode_o  output  3  slave A opcode
s_a_address_o  output  ADDR_W  slave A address
s_a_data_o  output  DATA_W  slave A data
s_a_size_o  output  2  slave A size
s_a_mask_o  output  2  slave A mask
s_a_ready_i  input  1  slave A accept
s_d_valid_i  input  1  slave D valid
s_d_opcode_i  input  3  slave D opcode (0 AccessAck, 1 AccessAckData)
s_d_size_i  input  2  slave D size
s_d_data_i  input  DATA_W  slave D data
s_d_ready_o  output  1  slave D accept
timeout_o  output  1  sticky watchdog flag

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; all valid/ready outputs 0; s_a_* payload registers 0; m_d_* payload 0.
  - owner=0; last_grant=1, so master 0 wins the first tie; timeout_o=0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any m_a_valid_i is set, pick the winner: the sole requester, or on a tie the master != last_grant.
  - m_a_ready_o[winner]=1 combinationally in that same cycle, and only then; the loser sees ready=0.
  - On the clock edge: latch the winner's opcode/address/data/size/mask into s_a_* registers; owner=winner; last_grant=winner; go to REQ.
- REQ:
  - s_a_valid_o=1 with the registered payload, held stable until s_a_ready_i=1.
  - On s_a_valid_o&s_a_ready_i: go to RESP.
  - All m_a_ready_o=0.
- RESP:
  - Combinational passthrough: m_d_valid_o[owner]=s_d_valid_i, other bit 0; m_d_* = s_d_*; s_d_ready_o = m_d_ready_i[owner].
  - On s_d_valid_i&s_d_ready_o: go to IDLE.
- Added latency: exactly 1 cycle on A (IDLE grant to s_a_valid_o); 0 cycles on D.
- Back-to-back throughput: a new grant can occur in the IDLE cycle immediately after the response handshake. Minimum 3 cycles per transaction with zero-wait slave.
- s_d_valid_i in IDLE or REQ:
  - s_d_ready_o=0; nothing forwarded; no state change.
- Master dropping valid before grant: no effect. A granted beat is already captured, so the transaction completes.
- Owner holding m_d_ready_i=0: the response stalls in RESP indefinitely (watchdog off); no new grants.
- Reset mid-transaction:
  - Returns to IDLE immediately and drops s_a_valid_o.
  - Any pending slave response is not forwarded until the next grant. The system resets slave and masters together.
- No outstanding-count beyond 1; no reordering.

Optional Feature:
- Macro: TLUL_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on RESP entry and increments each RESP cycle with no s_d_valid_i.
  - When it reaches TIMEOUT_CYCLES, the arbiter generates a local response:
    - m_d_valid_o[owner]=1
    - m_d_opcode_o=1 if the request was Get, else 0
    - m_d_data_o=32'hDEAD_BEEF, m_d_size_o = request size
  - It holds that response until m_d_ready_i[owner], then goes to IDLE.
  - timeout_o sets and stays 1 until reset.
  - A late s_d_valid_i is ignored with s_d_ready_o=0 while in IDLE.
- Not defined: no counter; timeout_o tied 0; RESP waits forever.

Test Plan:
- Master 0 Get addr 12'h010, slave returns AccessAckData 32'h0000_0013 -> m_a_ready_o=01 in grant cycle; s_a_valid_o next cycle with addr 12'h010, opcode 4; m_d_valid_o=01, data 32'h0000_0013; state IDLE after handshake.
- Both masters valid from reset (M0 Get 12'h000, M1 PutFull 12'h100 data 32'hCAFE_0001 mask 2'b11) -> M0 granted first; M1 granted next IDLE; slave sees Get then PutFull, in that order; M1 receives opcode 0.
- Both masters held valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
- Slave holds s_a_ready_i=0 for 4 cycles in REQ, and master 1 raises valid meanwhile -> s_a_* stable for all 4 cycles; m_a_ready_o stays 00; M1 served after M0's response.
- Slave asserts s_d_valid_i while in IDLE -> s_d_ready_o=0 and m_d_valid_o=00.
- Assert reset=0 during RESP -> all outputs 0 asynchronously; after release, a new M0 request completes normally.
- With TLUL_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never responds to a Get -> after 8 RESP cycles m_d_valid_o[owner]=1 with data 32'hDEAD_BEEF and opcode 1; timeout_o=1 stays high.
